// File: rtl/debug_dump_tx_if.sv
// Byte handshake between the debug dump serializer and the UART transmitter.
// valid/ready: o_tx_start is a one-cycle "take o_tx_data" strobe; i_tx_done is a one-cycle "byte finished" strobe.
interface debug_dump_tx_if;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done;

  modport master (
    output o_tx_start,
    output o_tx_data,
    input  i_tx_done
  );

  modport slave (
    input  o_tx_start,
    input  o_tx_data,
    output i_tx_done
  );
endinterface

// File: rtl/debug_dump_tx.sv
// Serializes a PC + register-file snapshot into a UART byte stream:
// header byte, PC (LSB first), then reg[0..NUM_REGS-1] (each LSB first).
module debug_dump_tx #(
  parameter int          NUM_REGS      = 32,
  parameter int          REG_ADDR_BITS = 5,
  parameter int          WORD_BITS     = 32,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [WORD_BITS-1:0]     i_pc,
  output logic [REG_ADDR_BITS-1:0] o_reg_addr,
  input  logic [WORD_BITS-1:0]     i_reg_data,
  debug_dump_tx_if.master          tx,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [2:0]               o_state
);

  localparam int BYTES  = WORD_BITS / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_WAIT   = 3'd2,
    S_FETCH  = 3'd3,
    S_LOAD   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR = 2'd0,
    PH_PC  = 2'd1,
    PH_REG = 2'd2
  } phase_t;

  state_t                   state_q, state_d;
  phase_t                   phase_q, phase_d;
  logic [WORD_BITS-1:0]     word_q, word_d;
  logic [WORD_BITS-1:0]     word_shift;
  logic [7:0]               tx_data_q, tx_data_d;
  logic [BIDX_W-1:0]        byte_idx_q, byte_idx_d;
  // One bit wider than the address so a full 2^REG_ADDR_BITS dump terminates.
  logic [REG_ADDR_BITS:0]   reg_idx_q, reg_idx_d;
  logic [REG_ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
  logic                     last_byte;
  logic                     more_regs;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_HDR;
      word_q     <= '0;
      tx_data_q  <= '0;
      byte_idx_q <= '0;
      reg_idx_q  <= '0;
      reg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      byte_idx_q <= byte_idx_d;
      reg_idx_q  <= reg_idx_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  assign word_shift = word_q >> 8;
  assign last_byte  = (byte_idx_q == BIDX_W'(BYTES - 1));
  assign more_regs  = (reg_idx_q < (REG_ADDR_BITS + 1)'(NUM_REGS));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    byte_idx_d = byte_idx_q;
    reg_idx_d  = reg_idx_q;
    reg_addr_d = reg_addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          word_d     = i_pc;
          tx_data_d  = HEADER_BYTE;
          phase_d    = PH_HDR;
          byte_idx_d = '0;
          reg_idx_d  = '0;
          reg_addr_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (tx.i_tx_done) begin
          if (phase_q == PH_HDR) begin
            // PC was captured at start, so it streams straight after the header.
            phase_d    = PH_PC;
            tx_data_d  = word_q[7:0];
            byte_idx_d = '0;
            state_d    = S_SEND;
          end else if (!last_byte) begin
            word_d     = word_shift;
            tx_data_d  = word_shift[7:0];
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_SEND;
          end else if (phase_q == PH_PC || more_regs) begin
            // Address moves now so the registered read is valid during LOAD.
            reg_addr_d = reg_idx_q[REG_ADDR_BITS-1:0];
            reg_idx_d  = reg_idx_q + 1'b1;
            phase_d    = PH_REG;
            state_d    = S_FETCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        word_d     = i_reg_data;
        tx_data_d  = i_reg_data[7:0];
        byte_idx_d = '0;
        state_d    = S_SEND;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign tx.o_tx_start = (state_q == S_SEND);
  assign tx.o_tx_data  = tx_data_q;
  assign o_busy        = (state_q == S_SEND) || (state_q == S_WAIT) ||
                         (state_q == S_FETCH) || (state_q == S_LOAD);
  assign o_done        = (state_q == S_FINISH);
  assign o_reg_addr    = reg_addr_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx: vector table for reset/handshake edges,
// plus full-frame sequences against a small transmitter and register-file model.
module tb_debug_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        busy, done;
  logic [2:0]  st;
  logic        model_done, man_done;

  debug_dump_tx_if tx_if ();
  assign tx_if.i_tx_done = model_done | man_done;

  debug_dump_tx dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_start    (start),
    .i_pc       (pc),
    .o_reg_addr (reg_addr),
    .i_reg_data (reg_data),
    .tx         (tx_if.master),
    .o_busy     (busy),
    .o_done     (done),
    .o_state    (st)
  );

  // ---------------- small DUT (4 registers) ----------------
  logic        start_s;
  logic [1:0]  reg_addr_s;
  logic [31:0] reg_data_s;
  logic        busy_s, done_s;
  logic [2:0]  st_s;
  logic        done_s_in;
  logic [31:0] pc_s;

  debug_dump_tx_if tx_if_s ();
  assign tx_if_s.i_tx_done = done_s_in;

  debug_dump_tx #(.NUM_REGS(4), .REG_ADDR_BITS(2)) dut_s (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_start    (start_s),
    .i_pc       (pc_s),
    .o_reg_addr (reg_addr_s),
    .i_reg_data (reg_data_s),
    .tx         (tx_if_s.master),
    .o_busy     (busy_s),
    .o_done     (done_s),
    .o_state    (st_s)
  );

  // Registered register-file read ports: data follows the address by one cycle.
  always @(posedge clk) reg_data   <= 32'h1100_0000 | 32'(reg_addr);
  always @(posedge clk) reg_data_s <= 32'h1100_0000 | 32'(reg_addr_s);

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         start_cyc_q[$];
  logic [7:0] got_s_q[$];
  int         start_s_cyc_q[$];
  int         done_s_cyc_q[$];

  bit   model_en  = 1'b0;
  bit   check_gap = 1'b0;
  int   tx_delay  = 20;
  bit   pend      = 1'b0;
  int   done_at   = 0;
  int   last_done_cyc = 0;
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  logic [7:0] last_sent = 8'h00;
  bit   pend_s    = 1'b0;
  int   done_at_s = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter model + monitor for the main DUT.
  always @(negedge clk) begin
    if (pend && cyc == done_at) begin
      model_done = 1'b1;
      pend = 1'b0;
    end else begin
      model_done = 1'b0;
    end
    if (model_done && st == 3'd2) last_done_cyc = cyc;
    if (tx_if.o_tx_start) begin
      got_q.push_back(tx_if.o_tx_data);
      start_cyc_q.push_back(cyc);
      last_sent = tx_if.o_tx_data;
      if (check_gap && got_q.size() > 1) begin
        int k;
        k = got_q.size() - 1;
        check($sformatf("gap_byte%0d", k), 32'(cyc - last_done_cyc),
              (k >= 5 && (k - 5) % 4 == 0) ? 32'd3 : 32'd1);
      end
      if (model_en) begin
        pend = 1'b1;
        done_at = cyc + tx_delay;
      end
    end else if (st == 3'd2) begin
      check("wait_hold", 32'(tx_if.o_tx_data), 32'(last_sent));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_low_at_done", 32'(busy), 32'd0);
    end
  end

  // Transmitter model + monitor for the small DUT (3-cycle byte time).
  always @(negedge clk) begin
    if (pend_s && cyc == done_at_s) begin
      done_s_in = 1'b1;
      pend_s = 1'b0;
    end else begin
      done_s_in = 1'b0;
    end
    if (tx_if_s.o_tx_start) begin
      got_s_q.push_back(tx_if_s.o_tx_data);
      start_s_cyc_q.push_back(cyc);
      pend_s = 1'b1;
      done_at_s = cyc + 3;
    end
    if (done_s) done_s_cyc_q.push_back(cyc);
  end

  task automatic build_exp(input logic [31:0] p, input int nregs);
    logic [31:0] w;
    exp_q.push_back(8'hA5);
    for (int b = 0; b < 4; b++) exp_q.push_back(p[8*b +: 8]);
    for (int r = 0; r < nregs; r++) begin
      w = 32'h1100_0000 | 32'(r);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_if.o_tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(tx_if.o_tx_data),  32'd0);
    check({tag, "_busy"},     32'(busy),             32'd0);
    check({tag, "_done"},     32'(done),             32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr),         32'd0);
  endtask

  // One frame with the main DUT; optional spurious inputs or a mid-frame reset.
  task automatic run_frame(input string tag, input int delay, input bit inj,
                           input int rst_at, input bit gap);
    int budget;
    int sz;
    bit did_s, did_p;
    got_q.delete();
    start_cyc_q.delete();
    done_cnt  = 0;
    tx_delay  = delay;
    model_en  = 1'b1;
    check_gap = gap;
    did_s = 1'b0;
    did_p = 1'b0;
    @(negedge clk);
    pc    = 32'h0040_0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 6000) begin
      @(negedge clk);
      budget++;
      start    = 1'b0;
      man_done = 1'b0;
      if (inj) begin
        if (!did_s && got_q.size() >= 5) begin
          start = 1'b1;
          did_s = 1'b1;
        end
        if (got_q.size() >= 3) pc = 32'hDEAD_BEEF;
        if (!did_p && st == 3'd4) begin
          man_done = 1'b1;
          did_p = 1'b1;
        end
      end
      if (rst_at > 0 && got_q.size() >= rst_at) break;
    end
    start    = 1'b0;
    man_done = 1'b0;
    if (rst_at > 0) begin
      check({tag, "_reached"}, 32'(got_q.size() >= rst_at), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs(tag);
      sz = got_q.size();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check({tag, "_no_more_bytes"}, 32'(got_q.size()), 32'(sz));
      check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
      check_gap = 1'b0;
      return;
    end
    check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    if (start_cyc_q.size() > 0)
      check({tag, "_done_latency"}, 32'(done_cyc - start_cyc_q[$]), 32'(delay + 1));
    repeat (5) @(negedge clk);
    check({tag, "_single_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_gap = 1'b0;
    exp_q.delete();
    build_exp(32'h0040_0010, 32);
    compare_stream(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        start;
    logic        done_in;
    logic [31:0] pc;
    logic        ts;
    logic        busy;
    logic        dn;
    logic [7:0]  data;
    logic [4:0]  addr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int budget;
    int seen;
    rst_n    = 1'b0;
    start    = 1'b1;
    pc       = 32'h0;
    man_done = 1'b0;
    start_s  = 1'b0;
    pc_s     = 32'h0000_1234;

    //          rst   start done  pc            ts    busy  dn    data   addr
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h00400010, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 8'h10, 5'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 8'h10, 5'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 8'h10, 5'd0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst;
      start    = vecs[i].start;
      pc       = vecs[i].pc;
      man_done = vecs[i].done_in;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_tx_start", i), 32'(tx_if.o_tx_start), 32'(vecs[i].ts));
      check($sformatf("vec%0d_busy", i),     32'(busy),             32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i),     32'(done),             32'(vecs[i].dn));
      check($sformatf("vec%0d_tx_data", i),  32'(tx_if.o_tx_data),  32'(vecs[i].data));
      check($sformatf("vec%0d_reg_addr", i), 32'(reg_addr),         32'(vecs[i].addr));
    end
    @(negedge clk);
    rst_n    = 1'b1;
    start    = 1'b0;
    man_done = 1'b0;
    repeat (3) @(negedge clk);

    run_frame("full",     20, 1'b0, 0,  1'b0);
    run_frame("spurious", 20, 1'b1, 0,  1'b0);
    run_frame("fast",     1,  1'b0, 0,  1'b1);
    run_frame("midreset", 20, 1'b0, 50, 1'b0);
    run_frame("after_rst", 20, 1'b0, 0, 1'b0);

    // Back-to-back frames on the 4-register instance with start held high.
    got_s_q.delete();
    start_s_cyc_q.delete();
    done_s_cyc_q.delete();
    @(negedge clk);
    start_s = 1'b1;
    seen = 0;
    budget = 0;
    while (seen < 2 && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (done_s) seen++;
    end
    start_s = 1'b0;
    check("b2b_done_count", 32'(seen), 32'd2);
    repeat (10) @(negedge clk);
    check("b2b_no_third_frame", 32'(got_s_q.size()), 32'd42);
    exp_q.delete();
    build_exp(32'h0000_1234, 4);
    build_exp(32'h0000_1234, 4);
    for (int i = 0; i < 42 && i < got_s_q.size(); i++)
      check($sformatf("b2b_byte%0d", i), 32'(got_s_q[i]), 32'(exp_q[i]));
    if (done_s_cyc_q.size() > 0 && start_s_cyc_q.size() > 21)
      check("b2b_idle_gap", 32'(start_s_cyc_q[21] - done_s_cyc_q[0]), 32'd2);
    else
      check("b2b_gap_data", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
